// File: rtl/q_fifo_bubl_regbp_pkg.sv
// Shared helpers for the registered-back-pressure stream FIFO.
// Ceil-log2 for widths and a wrapping pointer increment.
package q_defs;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Advance a ring pointer, wrapping n-1 back to 0.
    // n need not be a power of two.
    function automatic int ptr_inc(input int p, input int n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/q_fifo_bubl_regbp_ram.sv
// Storage array for the stream FIFO.
// Ports: clock; we_i/waddr_i/wdata_i sync write;
// raddr_i -> rdata_o async read. No reset.
module q_fifo_ram
    import q_defs::*;
#(
    parameter int depth = 16,
    parameter int width = 16,
    localparam int aw = clog2(depth)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [aw-1:0]    waddr_i,
    input  logic [width-1:0] wdata_i,
    input  logic [aw-1:0]    raddr_i,
    output logic [width-1:0] rdata_o
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/q_fifo_bubl_regbp.sv
// Stream FIFO with registered valid and back-pressure.
// Ports: clock, reset (async, active-low); i_d/i_v/i_b in stream;
// o_d/o_v/o_b out stream; count occupancy; ovf sticky drop flag.
module q_fifo_bubl_regbp
    import q_defs::*;
#(
    parameter int depth = 16,
    parameter int width = 16,
    parameter int slack = 1,
    localparam int cntwidth = clog2(depth) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [width-1:0]    i_d,
    input  logic                i_v,
    output logic                i_b,
    output logic [width-1:0]    o_d,
    output logic                o_v,
    input  logic                o_b,
    output logic [cntwidth-1:0] count,
    output logic                ovf
);

    localparam int aw = clog2(depth);
    localparam logic [cntwidth-1:0] FULL = cntwidth'(depth);
    localparam logic [cntwidth-1:0] THR  = cntwidth'(depth - slack);

    if (depth < 2) begin : g_bad_depth
        $error("q_fifo_bubl_regbp: depth must be >= 2");
    end
    if (slack >= depth || slack < 0) begin : g_bad_slack
        $error("q_fifo_bubl_regbp: slack must be in 0..depth-1");
    end

    logic [aw-1:0]       wp_q, wp_d;
    logic [aw-1:0]       rp_q, rp_d;
    logic [cntwidth-1:0] count_q, count_d;
    logic                ib_q, ib_d;
    logic                ovf_q, ovf_d;
    logic                deq, room, enq;

    // Valid comes only from the count flop, never from i_v.
    assign o_v  = (count_q != '0);
    assign deq  = o_v & ~o_b;
    // A full FIFO can still accept when the head leaves this cycle.
    assign room = (count_q != FULL) | deq;
    assign enq  = i_v & room;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q + cntwidth'(enq) - cntwidth'(deq);
        ovf_d   = ovf_q | (i_v & ~room);
        if (enq) wp_d = aw'(ptr_inc(32'(wp_q), depth));
        if (deq) rp_d = aw'(ptr_inc(32'(rp_q), depth));
        // Threshold on next count so i_b is a pure flop output.
        ib_d    = (count_d >= THR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ib_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ib_q    <= ib_d;
            ovf_q   <= ovf_d;
        end
    end

    q_fifo_ram #(
        .depth (depth),
        .width (width)
    ) u_ram (
        .clock   (clock),
        .we_i    (enq),
        .waddr_i (wp_q),
        .wdata_i (i_d),
        .raddr_i (rp_q),
        .rdata_o (o_d)
    );

    assign i_b   = ib_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_q_fifo_bubl_regbp.sv
// Randomised/directed bench for q_fifo_bubl_regbp.
// Two instances (depth 4 and depth 5) against queue models.
module tb_q_fifo_bubl_regbp;

    localparam int AD = 4;
    localparam int AS = 1;
    localparam int BD = 5;
    localparam int BS = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0] a_id, a_od, b_id, b_od;
    logic a_iv, a_ib, a_ov, a_ob, a_ovf;
    logic b_iv, b_ib, b_ov, b_ob, b_ovf;
    logic [2:0] a_cnt;
    logic [3:0] b_cnt;

    q_fifo_bubl_regbp #(.depth(AD), .width(8), .slack(AS)) u_a (
        .clock (clock), .reset (reset),
        .i_d (a_id), .i_v (a_iv), .i_b (a_ib),
        .o_d (a_od), .o_v (a_ov), .o_b (a_ob),
        .count (a_cnt), .ovf (a_ovf)
    );

    q_fifo_bubl_regbp #(.depth(BD), .width(8), .slack(BS)) u_b (
        .clock (clock), .reset (reset),
        .i_d (b_id), .i_v (b_iv), .i_b (b_ib),
        .o_d (b_od), .o_v (b_ov), .o_b (b_ob),
        .count (b_cnt), .ovf (b_ovf)
    );

    int checks = 0;
    int failures = 0;
    int b_enqs = 0;

    logic [7:0] aq[$];
    logic [7:0] bq[$];
    bit a_ovf_m = 1'b0;
    bit b_ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic post_chk();
        chk("a_cnt", 32'(a_cnt), 32'(aq.size()));
        chk("a_ov",  32'(a_ov),  32'(aq.size() != 0));
        chk("a_ib",  32'(a_ib),  32'(aq.size() >= AD - AS));
        chk("a_ovf", 32'(a_ovf), 32'(a_ovf_m));
        if (aq.size() != 0) chk("a_od", 32'(a_od), 32'(aq[0]));
        chk("b_cnt", 32'(b_cnt), 32'(bq.size()));
        chk("b_ov",  32'(b_ov),  32'(bq.size() != 0));
        chk("b_ib",  32'(b_ib),  32'(bq.size() >= BD - BS));
        chk("b_ovf", 32'(b_ovf), 32'(b_ovf_m));
        if (bq.size() != 0) chk("b_od", 32'(b_od), 32'(bq[0]));
        chk("b_cnt_max", 32'(b_cnt <= 4'(BD)), 32'd1);
    endtask

    // One clock: drive both streams, model the edge, check after it.
    task automatic step(input bit av, input logic [7:0] ad, input bit ab,
                        input bit bv, input logic [7:0] bd, input bit bb);
        bit adeq, aroom, aenq, bdeq, broom, benq;
        a_iv = av; a_id = ad; a_ob = ab;
        b_iv = bv; b_id = bd; b_ob = bb;
        #1;
        if (aq.size() != 0) chk("a_head", 32'(a_od), 32'(aq[0]));
        if (bq.size() != 0) chk("b_head", 32'(b_od), 32'(bq[0]));
        adeq  = (aq.size() != 0) && !ab;
        aroom = (aq.size() < AD) || adeq;
        aenq  = av && aroom;
        bdeq  = (bq.size() != 0) && !bb;
        broom = (bq.size() < BD) || bdeq;
        benq  = bv && broom;
        @(posedge clock);
        if (adeq) void'(aq.pop_front());
        if (aenq) aq.push_back(ad);
        if (av && !aroom) a_ovf_m = 1'b1;
        if (bdeq) void'(bq.pop_front());
        if (benq) begin
            bq.push_back(bd);
            b_enqs++;
        end
        if (bv && !broom) b_ovf_m = 1'b1;
        #1;
        post_chk();
        @(negedge clock);
    endtask

    task automatic a_step(input bit v, input logic [7:0] d, input bit b);
        step(v, d, b, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_a_ov",  32'(a_ov),  32'd0);
        chk("rst_a_ib",  32'(a_ib),  32'd0);
        chk("rst_a_ovf", 32'(a_ovf), 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        chk("rst_b_ov",  32'(b_ov),  32'd0);
        chk("rst_b_ib",  32'(b_ib),  32'd0);
        chk("rst_b_ovf", 32'(b_ovf), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        a_iv = 1'b0; a_id = '0; a_ob = 1'b1;
        b_iv = 1'b0; b_id = '0; b_ob = 1'b1;
        #2;
        chk_reset_outs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) a_step(1'b0, 8'h00, 1'b0);

        // Fill with o_b held, then drain in order.
        for (int i = 0; i < 4; i++) a_step(1'b1, 8'(8'hA1 + i), 1'b1);
        for (int i = 0; i < 5; i++) a_step(1'b0, 8'h00, 1'b0);

        // Full, streaming in and out at the same time.
        for (int i = 0; i < 4; i++) a_step(1'b1, 8'(8'hB0 + i), 1'b1);
        for (int i = 0; i < 8; i++) a_step(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("full_cnt", 32'(a_cnt), 32'd4);

        // Overflow while full and stalled.
        a_step(1'b1, 8'hFF, 1'b1);
        chk("ovf_set", 32'(a_ovf), 32'd1);
        for (int i = 0; i < 6; i++) a_step(1'b0, 8'h00, 1'b0);
        chk("ovf_sticky", 32'(a_ovf), 32'd1);

        // Random traffic on depth 5 to exercise wrap.
        for (int i = 0; i < 400 && b_enqs < 23; i++)
            step(1'b0, 8'h00, 1'b1,
                 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)));
        chk("b_enqs", 32'(b_enqs), 32'd23);
        for (int i = 0; i < 7; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("b_drained", 32'(bq.size()), 32'd0);

        // Reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) a_step(1'b1, 8'(8'hD0 + i), 1'b1);
        chk("pre_rst_cnt", 32'(a_cnt), 32'd3);
        reset = 1'b0;
        #1;
        aq.delete(); bq.delete();
        a_ovf_m = 1'b0; b_ovf_m = 1'b0;
        chk_reset_outs();
        @(negedge clock);
        reset = 1'b1;
        a_step(1'b1, 8'h5A, 1'b1);
        chk("first_post_rst", 32'(a_od), 32'h5A);
        a_step(1'b1, 8'h5B, 1'b0);
        a_step(1'b0, 8'h00, 1'b0);
        a_step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
